ibex_predict_redirect_ctrl: RTL and testbench
=============================================

Name: ibex_predict_redirect_ctrl

Overview:
Sequencer between the static branch predictor and the prefetch buffer in the IF stage. Turns predict-taken indications into redirect requests to the prefetch buffer. Tracks up to DEPTH predicted-taken branches in flight until EX resolves them. On a resolved-not-taken mispredict it issues a correcting redirect to the stored fall-through PC and flushes its tracking queue.

Parameters:
DEPTH, 2, max outstanding predicted-taken branches (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
predict_taken_i  in  1  predictor says taken (already qualified with fetch valid)
predict_pc_i  in  32  predicted target PC
fetch_pc_i  in  32  PC of the predicted instruction
fetch_compressed_i  in  1  predicted instruction is 16-bit
fetch_ready_i  in  1  ID accepts the fetched instruction this cycle
pred_block_o  out  1  IF must not present a new predicted instruction
redirect_req_o  out  1  redirect request to prefetch buffer
redirect_pc_o  out  32  redirect target
redirect_ack_i  in  1  prefetch buffer accepts redirect
resolve_valid_i  in  1  EX resolves oldest tracked branch
resolve_taken_i  in  1  resolved direction
flush_i  in  1  pipeline flush (exception/debug/ID-side jump)
mispredict_o  out  1  single-cycle pulse: correction launched
perf_pred_cnt_o  out  32  predictions accepted (optional feature)
perf_mispred_cnt_o  out  32  mispredicts (optional feature)

Behaviour:
- Reset: state IDLE; queue empty; redirect_req_o=0; redirect_pc_o=0; mispredict_o=0; pred_block_o=0; counters 0. Asserting rst_i mid-redirect drops redirect_req_o immediately (async).
- Queue: DEPTH-entry FIFO of 32-bit fall-through PCs. fall-through = fetch_pc_i + 2 if compressed, else + 4, computed mod 2^32 (wraps at 0xFFFFFFFF).
- States: IDLE, REDIRECT, CORRECT.
- push: predict_taken_i & fetch_ready_i & state==IDLE & !full & !flush_i & !mispredict_now. Effects:
  - fall-through is enqueued.
  - Next cycle: state=REDIRECT, redirect_req_o=1, redirect_pc_o=predict_pc_i (registered). Latency is 1 cycle.
- REDIRECT: hold req/pc stable until redirect_ack_i, then return to IDLE in the following cycle. An ack in the same cycle as req rise is legal.
- mispredict_now: resolve_valid_i & !resolve_taken_i & !empty & !flush_i. Effects:
  - Queue is cleared, including a same-cycle push, which is suppressed.
  - Next cycle: state=CORRECT, redirect_pc_o = head fall-through, redirect_req_o=1, mispredict_o pulses 1 cycle.
  - Legal from any state. A pending REDIRECT is abandoned; CORRECT supersedes it.
- resolve_valid_i & resolve_taken_i & !empty: pop head. A pop and a push in the same cycle leave the count unchanged.
- resolve_valid_i while empty: ignored. No pop, no state change.
- CORRECT: hold until redirect_ack_i, then go to IDLE. A second resolve in CORRECT is ignored (queue empty).
- flush_i: highest priority. Clears the queue. Next cycle: state=IDLE, redirect_req_o=0. The same-cycle push, pop and mispredict are all cancelled.
- pred_block_o (combinational) = (state!=IDLE) | full.
- full = count==DEPTH. Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.

Optional Feature:
- IBEX_PREDICT_PERF_EN defined:
  - perf_pred_cnt_o increments on every push.
  - perf_mispred_cnt_o increments on every mispredict_o pulse.
  - Both saturate at 0xFFFFFFFF and are not cleared by flush_i.
- Undefined: both outputs tied to 0 and no counter flops are present.

Test Plan:
- Push fetch_pc=0x100, 32-bit, target 0x0F0 -> next cycle redirect_req_o=1, redirect_pc_o=0x0F0. Ack 2 cycles later -> IDLE. Queue holds 0x104.
- Then resolve taken -> queue empty, no redirect, mispredict_o stays 0.
- Push compressed at 0x200 (target 0x1F8), ack. Then resolve not-taken -> mispredict_o pulse, redirect_pc_o=0x202, state CORRECT until ack.
- Push 2 entries (DEPTH=2) with acks -> pred_block_o=1 while full. A third predict_taken_i is not pushed. Resolve taken -> pred_block_o drops.
- Resolve not-taken during REDIRECT with target 0x300 pending (head fall-through 0x404) -> redirect_pc_o switches to 0x404 the next cycle. The 0x300 redirect is never acked.
- flush_i asserted in the same cycle as a push and a not-taken resolve -> no mispredict_o, queue empty, redirect_req_o=0 next cycle.
- Push fetch_pc=0xFFFFFFFE compressed, then resolve not-taken -> redirect_pc_o=0x00000000.
- With IBEX_PREDICT_PERF_EN: 3 pushes and 1 mispredict -> perf counts 3 and 1.

Source files
------------

// File: rtl/ibex_predict_redirect_ctrl.sv
// Predict-taken redirect sequencer between static predictor and prefetch buffer.
// Optional perf counters enabled by defining IBEX_PREDICT_PERF_EN.
module ibex_predict_redirect_ctrl #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        predict_taken_i,
    input  logic [31:0] predict_pc_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        fetch_compressed_i,
    input  logic        fetch_ready_i,
    output logic        pred_block_o,
    output logic        redirect_req_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ack_i,
    input  logic        resolve_valid_i,
    input  logic        resolve_taken_i,
    input  logic        flush_i,
    output logic        mispredict_o,
    output logic [31:0] perf_pred_cnt_o,
    output logic [31:0] perf_mispred_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        CORRECT  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [31:0]   fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic [31:0] redirect_pc_d;
    logic        mispredict_d;

    logic        full, empty;
    logic        mispredict_now;
    logic        push, pop, clear;
    logic [31:0] fall_through;
    logic [31:0] head_pc;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign fall_through = fetch_pc_i + (fetch_compressed_i ? 32'd2 : 32'd4);
    assign head_pc      = fifo_q[rd_ptr_q];

    assign mispredict_now = resolve_valid_i & ~resolve_taken_i & ~empty & ~flush_i;

    assign push = predict_taken_i & fetch_ready_i & (state_q == IDLE) &
                  ~full & ~flush_i & ~mispredict_now;

    assign pop   = resolve_valid_i & resolve_taken_i & ~empty & ~flush_i;
    assign clear = flush_i | mispredict_now;

    assign pred_block_o   = (state_q != IDLE) | full;
    assign redirect_req_o = (state_q != IDLE);

    // Queue: a clear wins over any same-cycle push or pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= fall_through;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            redirect_pc_o <= '0;
            mispredict_o  <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_pc_o <= redirect_pc_d;
            mispredict_o  <= mispredict_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_o;
        mispredict_d  = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
        end else if (mispredict_now) begin
            // A correction supersedes any redirect still awaiting ack.
            state_d       = CORRECT;
            redirect_pc_d = head_pc;
            mispredict_d  = 1'b1;
        end else if (push) begin
            state_d       = REDIRECT;
            redirect_pc_d = predict_pc_i;
        end else begin
            unique case (state_q)
                REDIRECT: if (redirect_ack_i) state_d = IDLE;
                CORRECT:  if (redirect_ack_i) state_d = IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

`ifdef IBEX_PREDICT_PERF_EN
    logic [31:0] pred_cnt_q, mispred_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pred_cnt_q    <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (push && pred_cnt_q != 32'hFFFF_FFFF) begin
                pred_cnt_q <= pred_cnt_q + 32'd1;
            end
            if (mispredict_d && mispred_cnt_q != 32'hFFFF_FFFF) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign perf_pred_cnt_o    = pred_cnt_q;
    assign perf_mispred_cnt_o = mispred_cnt_q;
`else
    assign perf_pred_cnt_o    = '0;
    assign perf_mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ibex_predict_redirect_ctrl.sv
// Directed self-checking bench for ibex_predict_redirect_ctrl (DEPTH=2).
module tb_ibex_predict_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        predict_taken;
    logic [31:0] predict_pc;
    logic [31:0] fetch_pc;
    logic        fetch_compressed;
    logic        fetch_ready;
    logic        pred_block;
    logic        redirect_req;
    logic [31:0] redirect_pc;
    logic        redirect_ack;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        flush;
    logic        mispredict;
    logic [31:0] perf_pred_cnt;
    logic [31:0] perf_mispred_cnt;

    int errors = 0;
    int checks = 0;

    ibex_predict_redirect_ctrl #(.DEPTH(2)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .predict_taken_i    (predict_taken),
        .predict_pc_i       (predict_pc),
        .fetch_pc_i         (fetch_pc),
        .fetch_compressed_i (fetch_compressed),
        .fetch_ready_i      (fetch_ready),
        .pred_block_o       (pred_block),
        .redirect_req_o     (redirect_req),
        .redirect_pc_o      (redirect_pc),
        .redirect_ack_i     (redirect_ack),
        .resolve_valid_i    (resolve_valid),
        .resolve_taken_i    (resolve_taken),
        .flush_i            (flush),
        .mispredict_o       (mispredict),
        .perf_pred_cnt_o    (perf_pred_cnt),
        .perf_mispred_cnt_o (perf_mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        predict_taken    = 1'b0;
        fetch_ready      = 1'b0;
        redirect_ack     = 1'b0;
        resolve_valid    = 1'b0;
        resolve_taken    = 1'b0;
        flush            = 1'b0;
    endtask

    // Drive a push for one cycle; caller then sees the registered redirect.
    task automatic do_push(input logic [31:0] fpc, input logic comp, input logic [31:0] tgt);
        predict_taken    = 1'b1;
        fetch_ready      = 1'b1;
        fetch_pc         = fpc;
        fetch_compressed = comp;
        predict_pc       = tgt;
        tick();
        predict_taken    = 1'b0;
        fetch_ready      = 1'b0;
    endtask

    task automatic do_ack();
        redirect_ack = 1'b1;
        tick();
        redirect_ack = 1'b0;
    endtask

    task automatic do_resolve(input logic taken);
        resolve_valid = 1'b1;
        resolve_taken = taken;
        tick();
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        predict_pc       = '0;
        fetch_pc         = '0;
        fetch_compressed = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("rst_req", {31'd0, redirect_req}, 32'd0);
        check("rst_pc", redirect_pc, 32'd0);
        check("rst_misp", {31'd0, mispredict}, 32'd0);
        check("rst_block", {31'd0, pred_block}, 32'd0);
        check("rst_perf_pred", perf_pred_cnt, 32'd0);
        check("rst_perf_misp", perf_mispred_cnt, 32'd0);
        rst = 1'b0;
        tick();

        do_push(32'h100, 1'b0, 32'h0F0);
        check("p1_req", {31'd0, redirect_req}, 32'd1);
        check("p1_pc", redirect_pc, 32'h0F0);
        check("p1_block", {31'd0, pred_block}, 32'd1);
        tick();
        check("p1_hold_req", {31'd0, redirect_req}, 32'd1);
        check("p1_hold_pc", redirect_pc, 32'h0F0);
        do_ack();
        check("p1_ack_req", {31'd0, redirect_req}, 32'd0);
        check("p1_ack_block", {31'd0, pred_block}, 32'd0);

        do_resolve(1'b1);
        check("rt_misp", {31'd0, mispredict}, 32'd0);
        check("rt_req", {31'd0, redirect_req}, 32'd0);
        do_resolve(1'b0);
        check("empty_nt_misp", {31'd0, mispredict}, 32'd0);
        check("empty_nt_req", {31'd0, redirect_req}, 32'd0);

        do_push(32'h200, 1'b1, 32'h1F8);
        check("p2_pc", redirect_pc, 32'h1F8);
        do_ack();
        do_resolve(1'b0);
        check("mp2_misp", {31'd0, mispredict}, 32'd1);
        check("mp2_req", {31'd0, redirect_req}, 32'd1);
        check("mp2_pc", redirect_pc, 32'h202);
        tick();
        check("mp2_pulse_end", {31'd0, mispredict}, 32'd0);
        check("mp2_hold_req", {31'd0, redirect_req}, 32'd1);
        do_ack();
        check("mp2_ack_req", {31'd0, redirect_req}, 32'd0);

        do_push(32'h500, 1'b0, 32'h600);
        do_ack();
        check("fill1_block", {31'd0, pred_block}, 32'd0);
        do_push(32'h510, 1'b0, 32'h700);
        check("fill2_pc", redirect_pc, 32'h700);
        do_ack();
        check("full_block", {31'd0, pred_block}, 32'd1);
        check("full_req", {31'd0, redirect_req}, 32'd0);
        predict_taken = 1'b1;
        fetch_ready   = 1'b1;
        fetch_pc      = 32'h520;
        predict_pc    = 32'h800;
        tick();
        predict_taken = 1'b0;
        fetch_ready   = 1'b0;
        check("full_nopush_req", {31'd0, redirect_req}, 32'd0);
        check("full_nopush_pc", redirect_pc, 32'h700);
        do_resolve(1'b1);
        check("pop_block", {31'd0, pred_block}, 32'd0);
        do_resolve(1'b0);
        check("head2_misp", {31'd0, mispredict}, 32'd1);
        check("head2_pc", redirect_pc, 32'h514);
        do_ack();

        do_push(32'h400, 1'b0, 32'h300);
        check("p3_pc", redirect_pc, 32'h300);
        do_resolve(1'b0);
        check("abandon_pc", redirect_pc, 32'h404);
        check("abandon_misp", {31'd0, mispredict}, 32'd1);
        check("abandon_req", {31'd0, redirect_req}, 32'd1);
        do_ack();
        check("abandon_ack_req", {31'd0, redirect_req}, 32'd0);

        do_push(32'h800, 1'b0, 32'h900);
        do_ack();
        flush         = 1'b1;
        predict_taken = 1'b1;
        fetch_ready   = 1'b1;
        fetch_pc      = 32'h810;
        predict_pc    = 32'hA00;
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        tick();
        idle_inputs();
        check("flush_misp", {31'd0, mispredict}, 32'd0);
        check("flush_req", {31'd0, redirect_req}, 32'd0);
        check("flush_block", {31'd0, pred_block}, 32'd0);
        do_resolve(1'b0);
        check("flush_empty_misp", {31'd0, mispredict}, 32'd0);

        do_push(32'hFFFF_FFFE, 1'b1, 32'h10);
        do_ack();
        do_resolve(1'b0);
        check("wrap_pc", redirect_pc, 32'h0);
        check("wrap_misp", {31'd0, mispredict}, 32'd1);
        do_ack();

`ifdef IBEX_PREDICT_PERF_EN
        check("perf_pred", perf_pred_cnt, 32'd7);
        check("perf_misp", perf_mispred_cnt, 32'd4);
`else
        check("perf_pred_off", perf_pred_cnt, 32'd0);
        check("perf_misp_off", perf_mispred_cnt, 32'd0);
`endif

        do_push(32'hC00, 1'b0, 32'hD00);
        check("arst_pre_req", {31'd0, redirect_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", {31'd0, redirect_req}, 32'd0);
        check("arst_pc", redirect_pc, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
